// File: rtl/rapid_pkg.sv
// Shared types and default sizes for the rapid core: register index and data word.
package rapid_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_idx_t;
  typedef logic [XLEN_DEF-1:0] word_t;
endpackage

// File: rtl/rapid_scoreboard.sv
// Per-register busy scoreboard: RAW/WAW hazard detection, issue gating, flush and
// a registered count of outstanding destination registers.
module rapid_scoreboard #(
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1,
  localparam int AW = $clog2(NREGS),
  localparam int CW = $clog2(NREGS + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_rs1,
  input  logic [AW-1:0] iss_rs2,
  input  logic [AW-1:0] iss_rd,
  input  logic          iss_rd_en,
  output logic          iss_ready,
  input  logic          flush,
  output logic [CW-1:0] pending_cnt
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_eff;
  logic [NREGS-1:0] busy_n;
  logic [CW-1:0]    cnt_n;
  logic             haz;
  logic             set_busy;

  // Handshake: an instruction issues on a cycle where iss_valid && iss_ready;
  // iss_ready never looks at iss_valid, so the decoder may hold valid freely.
  always_comb begin
    busy_eff = busy;
    if (wr_en) busy_eff[wr_addr] = 1'b0;
    haz       = busy_eff[iss_rs1] | busy_eff[iss_rs2] | (iss_rd_en & busy_eff[iss_rd]);
    iss_ready = ~haz & ~flush;
    set_busy  = iss_valid & iss_ready & iss_rd_en &
                ~((ZERO_REG != 0) && (iss_rd == '0));
  end

  // Set is applied after clear so a new producer keeps ownership on the same edge.
  always_comb begin
    busy_n = busy;
    if (flush) begin
      busy_n = '0;
    end else begin
      if (wr_en)    busy_n[wr_addr] = 1'b0;
      if (set_busy) busy_n[iss_rd]  = 1'b1;
    end
    cnt_n = '0;
    for (int i = 0; i < NREGS; i++) cnt_n = cnt_n + CW'(busy_n[i]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy        <= '0;
      pending_cnt <= '0;
    end else begin
      busy        <= busy_n;
      pending_cnt <= cnt_n;
    end
  end

endmodule

// File: rtl/rapid_regfile_sb.sv
// Register file with NRD registered write-first read ports, one write-back port,
// and the issue scoreboard.
module rapid_regfile_sb
  import rapid_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 4,
  parameter int ZERO_REG = 1,
  localparam int AW = $clog2(NREGS),
  localparam int CW = $clog2(NREGS + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rs1,
  input  logic [AW-1:0]     iss_rs2,
  input  logic [AW-1:0]     iss_rd,
  input  logic              iss_rd_en,
  output logic              iss_ready,
  input  logic              flush,
  output logic [CW-1:0]     pending_cnt
);

  logic [XLEN-1:0]     regs [NREGS];
  logic [NRD*XLEN-1:0] rd_data_n;
  logic                wr_ok;

  assign wr_ok = wr_en & ~((ZERO_REG != 0) && (wr_addr == '0));

  always_comb begin
    rd_data_n = '0;
    for (int i = 0; i < NRD; i++) begin
      if ((ZERO_REG != 0) && (rd_addr[i*AW +: AW] == '0))
        rd_data_n[i*XLEN +: XLEN] = '0;
      else if (wr_en && (wr_addr == rd_addr[i*AW +: AW]))
        rd_data_n[i*XLEN +: XLEN] = wr_data;
      else
        rd_data_n[i*XLEN +: XLEN] = regs[rd_addr[i*AW +: AW]];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      rd_data <= '0;
    end else begin
      if (wr_ok) regs[wr_addr] <= wr_data;
      rd_data <= rd_data_n;
    end
  end

  rapid_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .iss_valid   (iss_valid),
    .iss_rs1     (iss_rs1),
    .iss_rs2     (iss_rs2),
    .iss_rd      (iss_rd),
    .iss_rd_en   (iss_rd_en),
    .iss_ready   (iss_ready),
    .flush       (flush),
    .pending_cnt (pending_cnt)
  );

endmodule

// File: tb/tb_rapid_regfile_sb.sv
// Directed bench for rapid_regfile_sb: read/write-first/zero-reg, hazards, set-wins, flush, reset.
module tb_rapid_regfile_sb;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int NRD = 4;
  localparam int AW = 5;
  localparam int CW = 6;

  logic              clk;
  logic              reset_n;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [XLEN-1:0]   wr_data;
  logic              iss_valid;
  logic [AW-1:0]     iss_rs1;
  logic [AW-1:0]     iss_rs2;
  logic [AW-1:0]     iss_rd;
  logic              iss_rd_en;
  logic              iss_ready;
  logic              flush;
  logic [CW-1:0]     pending_cnt;

  int total = 0;
  int bad = 0;

  rapid_regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .iss_valid   (iss_valid),
    .iss_rs1     (iss_rs1),
    .iss_rs2     (iss_rs2),
    .iss_rd      (iss_rd),
    .iss_rd_en   (iss_rd_en),
    .iss_ready   (iss_ready),
    .flush       (flush),
    .pending_cnt (pending_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_valid = 1'b0; iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0; iss_rd_en = 1'b0;
    flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd_all(input logic [AW-1:0] a);
    for (int p = 0; p < NRD; p++) rd_addr[p*AW +: AW] = a;
  endtask

  task automatic issue(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [AW-1:0] rd, input logic rd_en);
    iss_valid = 1'b1; iss_rs1 = rs1; iss_rs2 = rs2; iss_rd = rd; iss_rd_en = rd_en;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  initial begin
    idle();
    rd_addr = '0;
    reset_n = 1'b0;
    #12;
    check("reset_rd_data", 64'(rd_data[XLEN-1:0]), 64'h0);
    check("reset_pending", 64'(pending_cnt), 64'd0);
    check("reset_ready", 64'(iss_ready), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // write then read on port 2
    write(5'd5, 32'hDEADBEEF);
    step();
    idle();
    rd_addr[2*AW +: AW] = 5'd5;
    step();
    check("rd_x5_port2", 64'(rd_data[2*XLEN +: XLEN]), 64'hDEADBEEF);

    // write-first on all ports
    write(5'd7, 32'h1234);
    set_rd_all(5'd7);
    step();
    idle();
    for (int p = 0; p < NRD; p++)
      check($sformatf("wfirst_port%0d", p), 64'(rd_data[p*XLEN +: XLEN]), 64'h1234);
    step();
    check("x7_stored", 64'(rd_data[XLEN-1:0]), 64'h1234);

    // zero register
    write(5'd0, 32'hFFFF_FFFF);
    set_rd_all(5'd0);
    step();
    idle();
    check("x0_wfirst", 64'(rd_data[XLEN-1:0]), 64'h0);
    step();
    check("x0_read", 64'(rd_data[3*XLEN +: XLEN]), 64'h0);
    issue(5'd0, 5'd0, 5'd0, 1'b1);
    #1;
    check("x0_issue_ready", 64'(iss_ready), 64'd1);
    step();
    idle();
    check("x0_pending", 64'(pending_cnt), 64'd0);
    issue(5'd0, 5'd0, 5'd0, 1'b1);
    #1;
    check("x0_not_busy", 64'(iss_ready), 64'd1);
    idle();

    // RAW stall and release bypass
    issue(5'd0, 5'd0, 5'd3, 1'b1);
    step();
    idle();
    check("x3_pending", 64'(pending_cnt), 64'd1);
    issue(5'd3, 5'd0, 5'd0, 1'b0);
    #1;
    check("raw_stall", 64'(iss_ready), 64'd0);
    write(5'd3, 32'hAAAA);
    #1;
    check("raw_bypass", 64'(iss_ready), 64'd1);
    step();
    idle();
    check("x3_released", 64'(pending_cnt), 64'd0);

    // write to a non-busy register leaves count alone
    write(5'd9, 32'h55);
    step();
    idle();
    check("free_write_pending", 64'(pending_cnt), 64'd0);

    // set wins over same-edge clear
    issue(5'd0, 5'd0, 5'd4, 1'b1);
    step();
    idle();
    check("x4_pending", 64'(pending_cnt), 64'd1);
    issue(5'd0, 5'd0, 5'd4, 1'b1);
    #1;
    check("waw_stall", 64'(iss_ready), 64'd0);
    write(5'd4, 32'h4444);
    #1;
    check("waw_bypass", 64'(iss_ready), 64'd1);
    step();
    idle();
    check("setwins_pending", 64'(pending_cnt), 64'd1);
    issue(5'd4, 5'd0, 5'd0, 1'b0);
    #1;
    check("setwins_busy", 64'(iss_ready), 64'd0);
    idle();
    write(5'd4, 32'h4445);
    step();
    idle();
    check("x4_cleared", 64'(pending_cnt), 64'd0);

    // flush
    issue(5'd0, 5'd0, 5'd1, 1'b1); step();
    issue(5'd0, 5'd0, 5'd2, 1'b1); step();
    issue(5'd0, 5'd0, 5'd6, 1'b1); step();
    idle();
    check("three_pending", 64'(pending_cnt), 64'd3);
    issue(5'd0, 5'd0, 5'd9, 1'b1);
    flush = 1'b1;
    write(5'd12, 32'hC0FFEE);
    #1;
    check("flush_ready", 64'(iss_ready), 64'd0);
    step();
    idle();
    check("flush_pending", 64'(pending_cnt), 64'd0);
    issue(5'd1, 5'd6, 5'd2, 1'b1);
    #1;
    check("post_flush_ready", 64'(iss_ready), 64'd1);
    idle();
    set_rd_all(5'd12);
    step();
    check("flush_keeps_write", 64'(rd_data[XLEN +: XLEN]), 64'hC0FFEE);

    // asynchronous reset mid-operation
    issue(5'd0, 5'd0, 5'd8, 1'b1);
    step();
    idle();
    check("pre_reset_pending", 64'(pending_cnt), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_pending", 64'(pending_cnt), 64'd0);
    check("async_rst_data", 64'(rd_data[XLEN +: XLEN]), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("rst_cleared_regs", 64'(rd_data[XLEN +: XLEN]), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
